// File: rtl/float7_pkg.sv
// rtl/float7_pkg.sv - shared constants, types and reference decode for the float7 decoder
// FLOAT7_MIDPOINT_EN: reference decode sets the MSB of the truncated field when e >= 2.
package float7_pkg;

   localparam int INT_W = 11;
   localparam int EXP_W = 3;
   localparam int MAN_W = 4;

   typedef struct packed {
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } float7_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [INT_W-1:0] f7_ref_decode(input float7_t c);
      logic [INT_W-1:0] v;
      v = {{(INT_W-MAN_W){1'b0}}, c.man};
      if (c.exp != '0) begin
         v = {{(INT_W-MAN_W-1){1'b0}}, 1'b1, c.man} << (c.exp - 3'd1);
`ifdef FLOAT7_MIDPOINT_EN
         if (c.exp >= 3'd2) begin
            v = v | (INT_W'(1) << (c.exp - 3'd2));
         end
`endif
      end
      return v;
   endfunction

endpackage

// File: rtl/float7_unpack.sv
// rtl/float7_unpack.sv - splits a float7 code into initial accumulator, shift count and midpoint mask
// FLOAT7_MIDPOINT_EN: mask holds bit (e-2) for e >= 2; otherwise the mask is zero.
module float7_unpack
   import float7_pkg::*;
(
   input  float7_t            code_i,
   output logic [INT_W-1:0]   acc_o,
   output logic [EXP_W-1:0]   cnt_o,
   output logic [INT_W-1:0]   mid_o
);

   always_comb begin
      acc_o = {{(INT_W-MAN_W-1){1'b0}}, (code_i.exp != '0), code_i.man};
      cnt_o = '0;
      mid_o = '0;
      if (code_i.exp != '0) begin
         cnt_o = code_i.exp - EXP_W'(1);
      end
`ifdef FLOAT7_MIDPOINT_EN
      // Bit e-2 sits just below the last shifted mantissa bit, so OR-ing it in never collides.
      if (code_i.exp >= EXP_W'(2)) begin
         mid_o = INT_W'(1) << (code_i.exp - EXP_W'(2));
      end
`endif
   end

endmodule

// File: rtl/float7_to_int11_seq.sv
// rtl/float7_to_int11_seq.sv - iterative float7 to 11-bit integer decoder with valid/ready on both sides
module float7_to_int11_seq
   import float7_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INT_W-1:0]       out_data
);

   state_t             state_q, state_d;
   logic [INT_W-1:0]   acc_q, acc_d;
   logic [INT_W-1:0]   mid_q, mid_d;
   logic [EXP_W-1:0]   cnt_q, cnt_d;

   float7_t            code;
   logic [INT_W-1:0]   acc_init;
   logic [INT_W-1:0]   mid_init;
   logic [EXP_W-1:0]   cnt_init;
   logic               accept;

   assign code   = float7_t'(in_data);
   assign accept = in_valid & in_ready;

   float7_unpack u_unpack (
      .code_i (code),
      .acc_o  (acc_init),
      .cnt_o  (cnt_init),
      .mid_o  (mid_init)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mid_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mid_q   <= mid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mid_d   = mid_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            // DONE with out_ready and a waiting code reloads directly, giving back-to-back results.
            if (accept) begin
               acc_d   = acc_init;
               mid_d   = mid_init;
               cnt_d   = cnt_init;
               state_d = (cnt_init == '0) ? DONE : SHIFT;
            end else if ((state_q == DONE) && out_ready) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            acc_d = acc_q << 1;
            cnt_d = cnt_q - EXP_W'(1);
            if (cnt_q == EXP_W'(1)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      out_valid = (state_q == DONE);
      out_data  = acc_q | mid_q;
   end

endmodule

// File: tb/tb_float7_to_int11_seq.sv
// tb/tb_float7_to_int11_seq.sv - self-checking bench: vector table, corner sequences, random sweep, round trip
`timescale 1ns/1ps
module tb_float7_to_int11_seq;
   import float7_pkg::*;

`ifdef FLOAT7_MIDPOINT_EN
   localparam bit MID = 1'b1;
`else
   localparam bit MID = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   float7_to_int11_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   typedef struct {
      logic [6:0] code;
      int         val;
      int         lat;
   } vec_t;

   function automatic int model(input int code);
      int e, m, v;
      e = code / 16;
      m = code % 16;
      if (e == 0) return m;
      v = (16 + m) * (2 ** (e - 1));
      if (MID && e >= 2) v = v + 2 ** (e - 2);
      return v;
   endfunction

   function automatic int model_lat(input int code);
      int e;
      e = code / 16;
      return (e == 0) ? 1 : e;
   endfunction

   function automatic int enc(input int x);
      int p;
      if (x < 16) return x;
      p = 0;
      while ((2 ** (p + 1)) <= x) p++;
      return (p - 3) * 16 + ((x / (2 ** (p - 4))) % 16);
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input logic [6:0] code, output int lat, output int val);
      int guard;
      in_valid = 1'b1;
      in_data  = code;
      #1;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      val = int'(out_data);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t vecs[8];
   int   order[128];

   initial begin
      int lat, val, held, guard, idx, got, cyc, tmp, j, bad;
      bit hold_prev;
      int hold_val;
      int q[$];

      vecs[0] = '{7'h09, 9,                 1};
      vecs[1] = '{7'h7F, MID ? 2016 : 1984, 7};
      vecs[2] = '{7'h10, 16,                1};
      vecs[3] = '{7'h35, MID ? 86 : 84,     3};
      vecs[4] = '{7'h00, 0,                 1};
      vecs[5] = '{7'h20, MID ? 33 : 32,     2};
      vecs[6] = '{7'h6A, MID ? 848 : 832,   6};
      vecs[7] = '{7'h4F, MID ? 252 : 248,   4};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data", int'(out_data), 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_one(vecs[i].code, lat, val);
         check($sformatf("vec%0d_data", i), val, vecs[i].val);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      end

      // Stall in DONE, then reload on the same cycle as the pop.
      in_valid = 1'b1; in_data = 7'h35;
      tick();
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 10) begin tick(); guard++; end
      held = int'(out_data);
      check("stall_first", held, MID ? 86 : 84);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", int'(out_valid), 1);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_data", int'(out_data), held);
         tick();
      end
      out_ready = 1'b1; in_valid = 1'b1; in_data = 7'h12;
      #1;
      check("reload_in_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check("reload_valid", int'(out_valid), 1);
      check("reload_data", int'(out_data), 18);
      tick();
      out_ready = 1'b0;
      check("drain_valid", int'(out_valid), 0);
      check("drain_keep_data", int'(out_data), 18);
      check("drain_in_ready", int'(in_ready), 1);

      // Reset while shifting.
      in_valid = 1'b1; in_data = 7'h6A;
      tick();
      in_valid = 1'b0;
      tick();
      check("shift_in_ready", int'(in_ready), 0);
      check("shift_out_valid", int'(out_valid), 0);
      rst = 1'b1;
      tick();
      check("rst_shift_valid", int'(out_valid), 0);
      check("rst_shift_data", int'(out_data), 0);
      check("rst_shift_in_ready", int'(in_ready), 1);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("rst_shift_stays_idle", int'(out_valid), 0);

      // Package reference agrees with the bench model on every code.
      bad = 0;
      for (int c = 0; c < 128; c++) begin
         if (int'(f7_ref_decode(float7_t'(7'(c)))) != model(c)) bad++;
      end
      check("pkg_ref_decode", bad, 0);

      // Random sweep of all codes with random gaps on both sides.
      for (int i = 0; i < 128; i++) order[i] = i;
      for (int i = 127; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      idx = 0; got = 0; cyc = 0; hold_prev = 1'b0; hold_val = 0;
      q.delete();
      while (got < 128 && cyc < 5000) begin
         in_valid  = (idx < 128) && ($urandom_range(0, 3) != 0);
         in_data   = (idx < 128) ? 7'(order[idx]) : 7'h0;
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (hold_prev) begin
            check("sweep_hold_valid", int'(out_valid), 1);
            check("sweep_hold_data", int'(out_data), hold_val);
         end
         hold_prev = out_valid && !out_ready;
         hold_val  = int'(out_data);
         if (out_valid && out_ready) begin
            if (q.size() == 0) check("sweep_unexpected", 1, 0);
            else check("sweep_data", int'(out_data), q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model(order[idx]));
            idx++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("sweep_count", got, 128);

      // Encoder round trip over every 11-bit value.
      tick(); tick();
      out_ready = 1'b1;
      idx = 0; got = 0; cyc = 0;
      q.delete();
      while (got < 2048 && cyc < 30000) begin
         in_valid = (idx < 2048);
         in_data  = (idx < 2048) ? 7'(enc(idx)) : 7'h0;
         #1;
         if (out_valid) begin
            if (q.size() == 0) check("rt_unexpected", 1, 0);
            else begin
               tmp = q.pop_front();
               check("rt_data", int'(out_data), model(enc(tmp)));
               if (!MID) check("rt_le_x", int'(int'(out_data) <= tmp), 1);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(idx);
            idx++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("rt_count", got, 2048);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
